btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 129 ++++++++++++
 tb/tb_btn_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, 4-state qualification FSM, edge pulses.
// Optional accepted-press counter enabled by defining BTN_DEBOUNCE_PRESS_COUNT_EN.
module btn_debounce #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       a_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] press_count
);

    localparam logic [1:0] StStableLow  = 2'd0;
    localparam logic [1:0] StWaitHigh   = 2'd1;
    localparam logic [1:0] StStableHigh = 2'd2;
    localparam logic [1:0] StWaitLow    = 2'd3;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Counter is only ever compared against CntMax and leaves WAIT on a match, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            StStableLow: begin
                if (sync2_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!sync2_q) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                    a_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStableHigh: begin
                if (!sync2_q) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (sync2_q) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StStableLow;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign a_out      = a_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
    logic [7:0] press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= 8'h00;
        end else if (rise_d) begin
            press_q <= press_q + 8'h01;
        end
    end

    assign press_count = press_q;
`else
    assign press_count = 8'h00;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing input, checked against a
// run-length reference model of the synchronized input.
module tb_btn_debounce;

    localparam int unsigned S = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       a_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] press_count;

    int total = 0;
    int bad   = 0;

    // Reference model: level accepted once S+1 consecutive synchronized samples disagree with it.
    logic m_s1, m_s2, m_a, m_rise, m_fall;
    int   m_run;
    int   m_pc;

    btn_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .a_out      (a_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_a = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_pc = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_s2 != m_a) m_run++;
            else m_run = 0;
            if (m_run == S + 1) begin
                m_a   = ~m_a;
                m_run = 0;
                if (m_a) begin
                    m_rise = 1'b1;
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
                    m_pc = (m_pc + 1) % 256;
`endif
                end else begin
                    m_fall = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk("a_out", {7'd0, a_out}, {7'd0, m_a});
        chk("rise_pulse", {7'd0, rise_pulse}, {7'd0, m_rise});
        chk("fall_pulse", {7'd0, fall_pulse}, {7'd0, m_fall});
        chk("press_count", press_count, m_pc[7:0]);
        chk("pulse_excl", {7'd0, rise_pulse & fall_pulse}, 8'd0);
    endtask

    initial begin
        int n;
        int len;
        logic lvl;
        logic [6:0] bounce;
        btn_in = 1'b0;
        rst    = 1'b1;
        m_s1 = 1'b0; m_s2 = 1'b0; m_a = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_pc = 0;

        // Reset, then quiet low input.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("reset_a_out", {7'd0, a_out}, 8'd0);
        chk("reset_pc", press_count, 8'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        chk("idle_a_out", {7'd0, a_out}, 8'd0);

        // Clean rise: a_out follows S+2 edges after the first sampling edge.
        tick(1'b1, 1'b0);
        n = 0;
        while (!a_out && n < 20) begin
            tick(1'b1, 1'b0);
            n++;
        end
        chk("rise_latency", n[7:0], 8'd6);
        chk("rise_pulse_at_edge", {7'd0, rise_pulse}, 8'd1);
        tick(1'b1, 1'b0);
        chk("rise_pulse_one_clk", {7'd0, rise_pulse}, 8'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

        // Clean fall.
        tick(1'b0, 1'b0);
        n = 0;
        while (a_out && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        chk("fall_latency", n[7:0], 8'd6);
        chk("fall_pulse_at_edge", {7'd0, fall_pulse}, 8'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

        // Bounce 1,1,0,1,1,1,0 repeated for 200 ns: never long enough to qualify.
        bounce = 7'b0111011;
        for (int i = 0; i < 10; i++) tick(bounce[i % 7], 1'b0);
        chk("bounce_a_out", {7'd0, a_out}, 8'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        chk("bounce_settled", {7'd0, a_out}, 8'd0);

        // Reset three clocks into a pending rise, then requalify from scratch.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("abort_a_out", {7'd0, a_out}, 8'd0);
        tick(1'b1, 1'b0);
        n = 0;
        while (!a_out && n < 20) begin
            tick(1'b1, 1'b0);
            n++;
        end
        chk("requal_latency", n[7:0], 8'd6);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

        // Random runs of random length with occasional resets.
        lvl = 1'b0;
        for (int r = 0; r < 60; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) tick(lvl, ($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);

        // 256 clean presses wrap the counter back to zero.
        tick(1'b0, 1'b1);
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        end
        chk("press_wrap", press_count, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
